// File: rtl/cp0_exc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cp0_exc_ctrl_pkg
// Purpose  : Shared constants for the coprocessor-0 exception controller.
//            Defines register numbers, ExcCode values, Status/Cause bit
//            positions, the MTC0-writable Status mask and a small helper
//            that identifies the address-error exception codes.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cp0_exc_ctrl_pkg;

  // CP0 register numbers
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Status bit positions
  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 8;
  localparam int STATUS_BEV   = 22;

  // Cause bit positions
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_TI     = 30;
  localparam int CAUSE_BD     = 31;

  // Status bits that MTC0 may change: BEV, IM[7:0], EXL, IE
  localparam logic [31:0] STATUS_WMASK = 32'h0040_ff03;

  // BadVAddr is only captured for address-error exceptions
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_exc_ctrl_timer.sv
`default_nettype none
// ============================================================================
// Module   : cp0_exc_ctrl_timer
// Purpose  : Count/Compare timer. A prescaler divides the core clock by
//            COUNT_DIV; Count increments each time the prescaler wraps.
//            TI latches when Count equals Compare and is cleared by a
//            Compare write.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            count_we          - MTC0 write to Count (also clears prescaler)
//            compare_we        - MTC0 write to Compare (also clears TI)
//            wdata[31:0]       - MTC0 write data
//            count[31:0]       - live Count value
//            compare[31:0]     - live Compare value
//            ti_o              - timer interrupt flag
// Revision : 1.0 - initial release
// ============================================================================
module cp0_exc_ctrl_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti_o
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

  logic [PW-1:0] presc;
  logic          ti;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      // A Count write overrides the increment and restarts the prescaler
      if (count_we) begin
        count <= wdata;
        presc <= '0;
      end else if (presc == PRESC_LAST) begin
        count <= count + 32'd1;
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end

      // Compare write clears TI even when it coincides with a match
      if (compare_we) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if (count == compare) begin
        ti <= 1'b1;
      end
    end
  end

  assign ti_o = ti;

endmodule
`default_nettype wire

// File: rtl/cp0_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cp0_exc_ctrl
// Purpose  : Coprocessor-0 register file and exception controller. Holds
//            BadVAddr, Count, Compare, Status, Cause and EPC; commits
//            exceptions and ERET; samples hardware interrupt lines; raises
//            the interrupt request and drives the fetch redirect.
// Ports    : clk, rst                     - clock, synchronous active-high reset
//            cp0_write_en/addr/data       - MTC0 write port
//            cp0_read_addr, data_o        - MFC0 read port (combinational)
//            exc_valid, exc_code,
//            exc_badvaddr, delayslot_flag,
//            current_pc_addr              - committed exception report
//            eret_flag                    - committed ERET
//            hw_int[HW_IRQ_NUM-1:0]       - level-sensitive interrupt lines
//            int_req_o                    - enabled interrupt pending
//            flush_o, flush_pc_o          - pipeline redirect
//            status_o, cause_o, epc_o     - live register values
// Revision : 1.0 - initial release
// ============================================================================
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter int          HW_IRQ_NUM = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hbfc0_0380,
  parameter logic [31:0] STATUS_RST = 32'h0040_ff00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cp0_write_en,
  input  logic [4:0]            cp0_write_addr,
  input  logic [31:0]           cp0_write_data,
  input  logic [4:0]            cp0_read_addr,
  output logic [31:0]           data_o,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  delayslot_flag,
  input  logic [31:0]           current_pc_addr,
  input  logic                  eret_flag,
  input  logic [HW_IRQ_NUM-1:0] hw_int,
  output logic                  int_req_o,
  output logic                  flush_o,
  output logic [31:0]           flush_pc_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o
);

  logic [31:0]           status;
  logic [31:0]           epc;
  logic [31:0]           badvaddr;
  logic                  cause_bd;
  logic [4:0]            cause_exc;
  logic [1:0]            ip_sw;
  logic [HW_IRQ_NUM-1:0] hw_q;
  logic [7:0]            ip;
  logic [31:0]           cause;
  logic [31:0]           count;
  logic [31:0]           compare;
  logic                  ti;

  logic we_count, we_compare, we_status, we_cause, we_epc;

  assign we_count   = cp0_write_en && (cp0_write_addr == REG_COUNT);
  assign we_compare = cp0_write_en && (cp0_write_addr == REG_COMPARE);
  assign we_status  = cp0_write_en && (cp0_write_addr == REG_STATUS);
  assign we_cause   = cp0_write_en && (cp0_write_addr == REG_CAUSE);
  assign we_epc     = cp0_write_en && (cp0_write_addr == REG_EPC);

  // Count/Compare are never touched by exceptions or ERET, so their
  // MTC0 writes are accepted unconditionally.
  cp0_exc_ctrl_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (we_count),
    .compare_we (we_compare),
    .wdata      (cp0_write_data),
    .count      (count),
    .compare    (compare),
    .ti_o       (ti)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      status    <= STATUS_RST;
      epc       <= '0;
      badvaddr  <= '0;
      cause_bd  <= 1'b0;
      cause_exc <= '0;
      ip_sw     <= '0;
      hw_q      <= '0;
    end else begin
      hw_q <= hw_int;

      if (exc_valid) begin
        // Exception owns Status, Cause, EPC and BadVAddr this cycle
        status[STATUS_EXL] <= 1'b1;
        cause_exc          <= exc_code;
        // Nested exception keeps the original return point
        if (!status[STATUS_EXL]) begin
          epc      <= delayslot_flag ? (current_pc_addr - 32'd4) : current_pc_addr;
          cause_bd <= delayslot_flag;
        end
        if (is_addr_exc(exc_code)) begin
          badvaddr <= exc_badvaddr;
        end
      end else begin
        if (eret_flag) begin
          // ERET owns Status only
          status[STATUS_EXL] <= 1'b0;
        end else if (we_status) begin
          status <= (status & ~STATUS_WMASK) | (cp0_write_data & STATUS_WMASK);
        end
        if (we_epc) begin
          epc <= cp0_write_data;
        end
        if (we_cause) begin
          ip_sw <= cp0_write_data[CAUSE_IP_LO +: 2];
        end
      end
    end
  end

  // Interrupt-pending vector: software bits, sampled lines, timer on IP7
  assign ip[1:0] = ip_sw;

  for (genvar i = 0; i < 5; i++) begin : g_ip
    if (i < HW_IRQ_NUM) begin : g_line
      assign ip[2+i] = hw_q[i];
    end else begin : g_none
      assign ip[2+i] = 1'b0;
    end
  end

  if (HW_IRQ_NUM == 6) begin : g_ip7_hw
    assign ip[7] = ti | hw_q[5];
  end else begin : g_ip7_ti
    assign ip[7] = ti;
  end

  assign cause = {cause_bd, ti, 14'b0, ip, 1'b0, cause_exc, 2'b00};

  always_comb begin
    data_o = '0;
    if (!rst) begin
      case (cp0_read_addr)
        REG_BADVADDR: data_o = badvaddr;
        REG_COUNT:    data_o = count;
        REG_COMPARE:  data_o = compare;
        REG_STATUS:   data_o = status;
        REG_CAUSE:    data_o = cause;
        REG_EPC:      data_o = epc;
        default:      data_o = '0;
      endcase
    end
  end

  assign int_req_o = status[STATUS_IE] & ~status[STATUS_EXL] &
                     (|(ip & status[STATUS_IM_LO +: 8]));

  // EPC written by MTC0 alongside ERET only becomes visible next cycle
  assign flush_o    = exc_valid | eret_flag;
  assign flush_pc_o = exc_valid ? EXC_VECTOR : epc;

  assign status_o = status;
  assign cause_o  = cause;
  assign epc_o    = epc;

endmodule
`default_nettype wire

// File: tb/tb_cp0_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_exc_ctrl
// Purpose  : Directed self-checking bench for cp0_exc_ctrl (two interrupt
//            lines, Count prescaler of 2).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cp0_write_en = 1'b0;
  logic [4:0]  cp0_write_addr = '0;
  logic [31:0] cp0_write_data = '0;
  logic [4:0]  cp0_read_addr = '0;
  logic [31:0] data_o;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_code = '0;
  logic [31:0] exc_badvaddr = '0;
  logic        delayslot_flag = 1'b0;
  logic [31:0] current_pc_addr = '0;
  logic        eret_flag = 1'b0;
  logic [1:0]  hw_int = '0;
  logic        int_req_o;
  logic        flush_o;
  logic [31:0] flush_pc_o;
  logic [31:0] status_o, cause_o, epc_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cp0_exc_ctrl #(
    .HW_IRQ_NUM (2),
    .COUNT_DIV  (2),
    .EXC_VECTOR (32'hbfc0_0380),
    .STATUS_RST (32'h0040_ff00)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cp0_write_en    (cp0_write_en),
    .cp0_write_addr  (cp0_write_addr),
    .cp0_write_data  (cp0_write_data),
    .cp0_read_addr   (cp0_read_addr),
    .data_o          (data_o),
    .exc_valid       (exc_valid),
    .exc_code        (exc_code),
    .exc_badvaddr    (exc_badvaddr),
    .delayslot_flag  (delayslot_flag),
    .current_pc_addr (current_pc_addr),
    .eret_flag       (eret_flag),
    .hw_int          (hw_int),
    .int_req_o       (int_req_o),
    .flush_o         (flush_o),
    .flush_pc_o      (flush_pc_o),
    .status_o        (status_o),
    .cause_o         (cause_o),
    .epc_o           (epc_o)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0_write_en   = 1'b1;
    cp0_write_addr = a;
    cp0_write_data = d;
    cyc();
    cp0_write_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    cp0_read_addr = 5'd12;
    #1;
    checks++;
    if (data_o !== 32'h0) begin
      errors++; $display("FAIL rst_data_o: got %h exp %h", data_o, 32'h0);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (data_o !== 32'h0040ff00) begin
      errors++; $display("FAIL rd_status: got %h exp %h", data_o, 32'h0040ff00);
    end
    cp0_read_addr = 5'd13;
    #1;
    checks++;
    if (data_o !== 32'h0) begin
      errors++; $display("FAIL rd_cause: got %h exp %h", data_o, 32'h0);
    end
    cp0_read_addr = 5'd9;
    #1;
    checks++;
    if (data_o !== 32'h0) begin
      errors++; $display("FAIL rd_count: got %h exp %h", data_o, 32'h0);
    end
    cp0_read_addr = 5'd3;
    #1;
    checks++;
    if (data_o !== 32'h0) begin
      errors++; $display("FAIL rd_unmapped: got %h exp %h", data_o, 32'h0);
    end
    checks++;
    if (epc_o !== 32'h0 || int_req_o !== 1'b0 || flush_o !== 1'b0) begin
      errors++; $display("FAIL rst_misc: epc %h int %b flush %b exp 0 0 0", epc_o, int_req_o, flush_o);
    end
  endtask

  task automatic test_timer();
    mtc0(5'd11, 32'd5);
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd9, 32'd0);
    checks++;
    if (int_req_o !== 1'b0) begin
      errors++; $display("FAIL timer_noint: got %b exp 0", int_req_o);
    end
    repeat (10) cyc();
    cp0_read_addr = 5'd9;
    #1;
    checks++;
    if (data_o !== 32'd5) begin
      errors++; $display("FAIL count_at_10: got %0d exp 5", data_o);
    end
    cyc();
    checks++;
    if (cause_o[30] !== 1'b1 || int_req_o !== 1'b1) begin
      errors++; $display("FAIL timer_ti: ti %b int %b exp 1 1", cause_o[30], int_req_o);
    end
    mtc0(5'd11, 32'd100);
    checks++;
    if (cause_o[30] !== 1'b0 || int_req_o !== 1'b0) begin
      errors++; $display("FAIL ti_clear: ti %b int %b exp 0 0", cause_o[30], int_req_o);
    end
  endtask

  task automatic test_exception();
    exc_valid = 1'b1; exc_code = 5'd4; exc_badvaddr = 32'h1003;
    current_pc_addr = 32'hbfc0_0104; delayslot_flag = 1'b1;
    #1;
    checks++;
    if (flush_o !== 1'b1 || flush_pc_o !== 32'hbfc0_0380) begin
      errors++; $display("FAIL exc_flush: flush %b pc %h exp 1 bfc00380", flush_o, flush_pc_o);
    end
    cyc();
    exc_valid = 1'b0;
    cp0_read_addr = 5'd8;
    #1;
    checks++;
    if (epc_o !== 32'hbfc0_0100 || cause_o[31] !== 1'b1 || cause_o[6:2] !== 5'd4 ||
        data_o !== 32'h1003 || status_o[1] !== 1'b1) begin
      errors++; $display("FAIL exc_adel: epc %h bd %b code %0d bva %h exl %b exp bfc00100 1 4 1003 1",
                         epc_o, cause_o[31], cause_o[6:2], data_o, status_o[1]);
    end
    exc_valid = 1'b1; exc_code = 5'd8; exc_badvaddr = 32'hdead;
    current_pc_addr = 32'h200; delayslot_flag = 1'b0;
    cyc();
    exc_valid = 1'b0;
    #1;
    checks++;
    if (epc_o !== 32'hbfc0_0100 || cause_o[31] !== 1'b1 || cause_o[6:2] !== 5'd8 || data_o !== 32'h1003) begin
      errors++; $display("FAIL exc_nested: epc %h bd %b code %0d bva %h exp bfc00100 1 8 1003",
                         epc_o, cause_o[31], cause_o[6:2], data_o);
    end
    eret_flag = 1'b1;
    #1;
    checks++;
    if (flush_o !== 1'b1 || flush_pc_o !== 32'hbfc0_0100) begin
      errors++; $display("FAIL eret_flush: flush %b pc %h exp 1 bfc00100", flush_o, flush_pc_o);
    end
    cyc();
    eret_flag = 1'b0;
    checks++;
    if (status_o[1] !== 1'b0) begin
      errors++; $display("FAIL eret_exl: got %b exp 0", status_o[1]);
    end
    mtc0(5'd8, 32'h0);
    cp0_read_addr = 5'd8;
    #1;
    checks++;
    if (data_o !== 32'h1003) begin
      errors++; $display("FAIL badvaddr_ro: got %h exp 00001003", data_o);
    end
  endtask

  task automatic test_priority();
    mtc0(5'd12, 32'h0000_ff00);
    exc_valid = 1'b1; exc_code = 5'd12; current_pc_addr = 32'h300; delayslot_flag = 1'b0;
    cp0_write_en = 1'b1; cp0_write_addr = 5'd12; cp0_write_data = 32'h0;
    cyc();
    exc_valid = 1'b0; cp0_write_en = 1'b0;
    checks++;
    if (status_o[1] !== 1'b1 || status_o[15:8] !== 8'hff || epc_o !== 32'h300 || cause_o[31] !== 1'b0) begin
      errors++; $display("FAIL exc_over_mtc0: exl %b im %h epc %h bd %b exp 1 ff 300 0",
                         status_o[1], status_o[15:8], epc_o, cause_o[31]);
    end
    eret_flag = 1'b1;
    cp0_write_en = 1'b1; cp0_write_addr = 5'd14; cp0_write_data = 32'h400;
    #1;
    checks++;
    if (flush_pc_o !== 32'h300) begin
      errors++; $display("FAIL eret_no_bypass: got %h exp 00000300", flush_pc_o);
    end
    cyc();
    eret_flag = 1'b0; cp0_write_en = 1'b0;
    checks++;
    if (epc_o !== 32'h400 || status_o[1] !== 1'b0) begin
      errors++; $display("FAIL eret_epc_wr: epc %h exl %b exp 400 0", epc_o, status_o[1]);
    end
    mtc0(5'd11, 32'h50);
    mtc0(5'd9, 32'h50);
    mtc0(5'd11, 32'h50);
    checks++;
    if (cause_o[30] !== 1'b0) begin
      errors++; $display("FAIL cmp_wr_match: ti got %b exp 0", cause_o[30]);
    end
    mtc0(5'd11, 32'hffff_0000);
  endtask

  task automatic test_hw_irq();
    mtc0(5'd12, 32'h0000_0801);
    hw_int = 2'b10;
    #1;
    checks++;
    if (cause_o[11] !== 1'b0) begin
      errors++; $display("FAIL hw_not_yet: got %b exp 0", cause_o[11]);
    end
    cyc();
    checks++;
    if (cause_o[11] !== 1'b1 || cause_o[10] !== 1'b0 || cause_o[15:12] !== 4'h0 || int_req_o !== 1'b1) begin
      errors++; $display("FAIL hw_sample: ip %h int %b exp 08 1", cause_o[15:8], int_req_o);
    end
    hw_int = 2'b00;
    cyc();
    checks++;
    if (cause_o[11] !== 1'b0 || int_req_o !== 1'b0) begin
      errors++; $display("FAIL hw_release: ip3 %b int %b exp 0 0", cause_o[11], int_req_o);
    end
    mtc0(5'd13, 32'hffff_ffff);
    checks++;
    if (cause_o[9:8] !== 2'b11 || cause_o[29:16] !== 14'h0 || cause_o[6:2] !== 5'd12 || cause_o[31] !== 1'b0) begin
      errors++; $display("FAIL cause_wr: got %h exp 00000330", cause_o);
    end
  endtask

  initial begin
    test_reset();
    test_timer();
    test_exception();
    test_priority();
    test_hw_irq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
